vend_dispense_sequencer: RTL

//  Sequences one vend after main_controller grants it: drives the selected slot motor,

---
 rtl/vend_if.sv | 31 +++
 rtl/vend_dispense_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vend_if.sv
// rtl/vend_if.sv - controller/driver-side bundle of the dispense sequencer.
// master = main_controller and sensors side, slave = the sequencer itself.
interface vend_if #(
  parameter int SLOT_W   = 3,
  parameter int CREDIT_W = 8
);
  logic                   cfg_mode;
  logic                   disp_req;
  logic [SLOT_W-1:0]      slot_sel;
  logic [CREDIT_W-1:0]    credit;
  logic [CREDIT_W-1:0]    price;
  logic                   drop_sense;
  logic                   fault_clr;
  logic                   busy;
  logic [(1<<SLOT_W)-1:0] motor_en;
  logic                   coin_out;
  logic [CREDIT_W-1:0]    change_rem;
  logic                   done;
  logic                   vend_ok;
  logic                   fault;

  modport master (
    output cfg_mode, disp_req, slot_sel, credit, price, drop_sense, fault_clr,
    input  busy, motor_en, coin_out, change_rem, done, vend_ok, fault
  );

  modport slave (
    input  cfg_mode, disp_req, slot_sel, credit, price, drop_sense, fault_clr,
    output busy, motor_en, coin_out, change_rem, done, vend_ok, fault
  );
endinterface

// File: rtl/vend_dispense_sequencer.sv
// rtl/vend_dispense_sequencer.sv - one-vend sequencer: motor drive, drop wait, coin change payout.
// motor_en/coin_out/busy/done decode straight from state so async reset silences them at once.
module vend_dispense_sequencer #(
  parameter int SLOT_W       = 3,
  parameter int CREDIT_W     = 8,
  parameter int MOTOR_CYC    = 16,
  parameter int DROP_TIMEOUT = 64,
  parameter int COIN_VAL     = 5,
  parameter int COIN_PULSE   = 4
) (
  input  logic clk,
  input  logic rst,
  vend_if.slave bus
);

  localparam int NSLOT   = 1 << SLOT_W;
  localparam int CNT_MAX = (MOTOR_CYC > DROP_TIMEOUT)
                           ? ((MOTOR_CYC > 2*COIN_PULSE) ? MOTOR_CYC : 2*COIN_PULSE)
                           : ((DROP_TIMEOUT > 2*COIN_PULSE) ? DROP_TIMEOUT : 2*COIN_PULSE);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    MOTOR_LAST = CNT_W'(MOTOR_CYC - 1);
  localparam logic [CNT_W-1:0]    DROP_LAST  = CNT_W'(DROP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    COIN_LAST  = CNT_W'(2*COIN_PULSE - 1);
  localparam logic [CNT_W-1:0]    PULSE_HI   = CNT_W'(COIN_PULSE);
  localparam logic [CREDIT_W-1:0] COIN_V     = CREDIT_W'(COIN_VAL);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MOTOR, S_WAIT_DROP, S_CHANGE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] chg_q, chg_d;
  logic [CREDIT_W-1:0] change_rem_q, change_rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_seen_q, drop_seen_d;
  logic                pend_q, pend_d;
  logic                fault_q, fault_d;
  logic [NSLOT-1:0]    motor_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      credit_q     <= '0;
      price_q      <= '0;
      chg_q        <= '0;
      change_rem_q <= '0;
      cnt_q        <= '0;
      drop_seen_q  <= 1'b0;
      pend_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      credit_q     <= credit_d;
      price_q      <= price_d;
      chg_q        <= chg_d;
      change_rem_q <= change_rem_d;
      cnt_q        <= cnt_d;
      drop_seen_q  <= drop_seen_d;
      pend_q       <= pend_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    credit_d     = credit_q;
    price_d      = price_q;
    chg_d        = chg_q;
    change_rem_d = change_rem_q;
    cnt_d        = cnt_q;
    drop_seen_d  = drop_seen_q;
    pend_d       = pend_q;
    fault_d      = fault_q;
    case (state_q)
      S_IDLE: begin
        if (bus.fault_clr) fault_d = 1'b0;
        if (bus.disp_req && !bus.cfg_mode && !fault_q) begin
          slot_d       = bus.slot_sel;
          credit_d     = bus.credit;
          price_d      = bus.price;
          change_rem_d = '0;
          drop_seen_d  = 1'b0;
          cnt_d        = '0;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (credit_q < price_q) begin
          chg_d   = credit_q;
          pend_d  = 1'b0;
          state_d = S_CHANGE;
        end else begin
          chg_d   = credit_q - price_q;
          state_d = S_MOTOR;
        end
      end
      S_MOTOR: begin
        if (bus.drop_sense) drop_seen_d = 1'b1;
        if (cnt_q == MOTOR_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_DROP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DROP: begin
        // A drop on the final timeout cycle is checked first, so it wins.
        if (drop_seen_q || bus.drop_sense) begin
          pend_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_CHANGE;
        end else if (cnt_q == DROP_LAST) begin
          fault_d = 1'b1;
          chg_d   = credit_q;
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHANGE: begin
        if (chg_q < COIN_V) begin
          change_rem_d = chg_q;
          state_d      = S_DONE;
        end else if (cnt_q == COIN_LAST) begin
          cnt_d = '0;
          chg_d = chg_q - COIN_V;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    motor_c = '0;
    if (state_q == S_MOTOR) motor_c[slot_q] = 1'b1;
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.motor_en   = motor_c;
  assign bus.coin_out   = (state_q == S_CHANGE) && (chg_q >= COIN_V) && (cnt_q < PULSE_HI);
  assign bus.change_rem = change_rem_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.vend_ok    = (state_q == S_DONE) && pend_q;
  assign bus.fault      = fault_q;

endmodule
